// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encodings,
// port indices and data width.
package dmem_pkg;

  localparam int DATA_W    = 8;
  localparam int PORT_CPU  = 0;
  localparam int PORT_DMA  = 1;
  localparam int NUM_PORTS = 2;

  typedef enum logic {
    ARB      = 1'b0,
    DMA_LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_rd_capture.sv
// Per-port read-return register: captures memory data on a granted read and
// pulses rvalid for the following cycle. rdata holds until the next read.
module dmem_rd_capture
  import dmem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              capture,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= capture;
      if (capture) begin
        rdata_reg <= mem_read_data;
      end
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;

endmodule

// File: rtl/dmem_port_arbiter.sv
// CPU/DMA arbiter for the single-port data memory. CPU has priority, DMA is
// forced through after a run of CPU wins and may lock the port for bursts.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDRESS_LINE = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDRESS_LINE-1:0] cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_gnt,
  output logic                    cpu_stall,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_rvalid,
  input  logic                    dma_req,
  input  logic                    dma_we,
  input  logic [ADDRESS_LINE-1:0] dma_addr,
  input  logic [DATA_W-1:0]       dma_wdata,
  input  logic                    dma_lock,
  output logic                    dma_gnt,
  output logic [DATA_W-1:0]       dma_rdata,
  output logic                    dma_rvalid,
  output logic [ADDRESS_LINE-1:0] mem_address,
  output logic [DATA_W-1:0]       mem_write_data,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [DATA_W-1:0]       mem_read_data
);

  localparam int STARVE_W    = $clog2(STARVE_LIMIT + 1);
  localparam int LOCK_W      = $clog2(LOCK_MAX + 1);
  localparam bit LOCK_ENABLE = (LOCK_MAX > 1);

  state_t                  state_reg, state_next;
  logic [STARVE_W-1:0]     starve_cnt_reg, starve_cnt_next;
  logic [LOCK_W-1:0]       lock_cnt_reg, lock_cnt_next;
  logic                    dma_forced;

  logic [NUM_PORTS-1:0]    req, we, gnt, rvalid;
  logic [ADDRESS_LINE-1:0] addr  [NUM_PORTS];
  logic [DATA_W-1:0]       wdata [NUM_PORTS];
  logic [DATA_W-1:0]       rdata [NUM_PORTS];

  assign req[PORT_CPU]   = cpu_req;
  assign we[PORT_CPU]    = cpu_we;
  assign addr[PORT_CPU]  = cpu_addr;
  assign wdata[PORT_CPU] = cpu_wdata;
  assign req[PORT_DMA]   = dma_req;
  assign we[PORT_DMA]    = dma_we;
  assign addr[PORT_DMA]  = dma_addr;
  assign wdata[PORT_DMA] = dma_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ARB;
      starve_cnt_reg <= '0;
      lock_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      lock_cnt_reg   <= lock_cnt_next;
    end
  end

  // A lock of length one is just the ARB grant, so the lock state is skipped.
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    case (state_reg)
      ARB: begin
        lock_cnt_next = '0;
        if (LOCK_ENABLE && gnt[PORT_DMA] && dma_lock) begin
          state_next    = DMA_LOCK;
          lock_cnt_next = LOCK_W'(1);
        end
      end
      DMA_LOCK: begin
        lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
        if (!req[PORT_DMA] || !dma_lock || lock_cnt_next == LOCK_W'(LOCK_MAX)) begin
          state_next    = ARB;
          lock_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ARB;
        lock_cnt_next = '0;
      end
    endcase

    starve_cnt_next = starve_cnt_reg;
    if (gnt[PORT_DMA] || !req[PORT_DMA]) begin
      starve_cnt_next = '0;
    end else if (gnt[PORT_CPU] && starve_cnt_reg < STARVE_W'(STARVE_LIMIT)) begin
      starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
    end
  end

  assign dma_forced = (starve_cnt_reg == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    gnt = '0;
    if (!reset) begin
      case (state_reg)
        ARB: begin
          if (req[PORT_DMA] && (!req[PORT_CPU] || dma_forced)) begin
            gnt[PORT_DMA] = 1'b1;
          end else if (req[PORT_CPU]) begin
            gnt[PORT_CPU] = 1'b1;
          end
        end
        DMA_LOCK: gnt[PORT_DMA] = req[PORT_DMA];
        default:  gnt = '0;
      endcase
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    if (gnt[PORT_DMA]) begin
      mem_address    = addr[PORT_DMA];
      mem_write_data = wdata[PORT_DMA];
    end else if (gnt[PORT_CPU]) begin
      mem_address    = addr[PORT_CPU];
      mem_write_data = wdata[PORT_CPU];
    end
  end

  assign mem_write = |(gnt & we);
  assign mem_read  = |(gnt & ~we);

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_capture
      dmem_rd_capture u_capture (
        .clock         (clock),
        .reset         (reset),
        .capture       (gnt[gi] & ~we[gi]),
        .mem_read_data (mem_read_data),
        .rdata         (rdata[gi]),
        .rvalid        (rvalid[gi])
      );
    end
  endgenerate

  assign cpu_gnt    = gnt[PORT_CPU];
  assign cpu_stall  = cpu_req & ~gnt[PORT_CPU];
  assign cpu_rdata  = rdata[PORT_CPU];
  assign cpu_rvalid = rvalid[PORT_CPU];
  assign dma_gnt    = gnt[PORT_DMA];
  assign dma_rdata  = rdata[PORT_DMA];
  assign dma_rvalid = rvalid[PORT_DMA];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter against a cycle-level
// behavioural model with its own image of memory contents.
module tb_dmem_port_arbiter;

  localparam int AW = 8;
  localparam int SL = 4;
  localparam int LM = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [7:0]    cpu_wdata, dma_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [7:0]    cpu_rdata, dma_rdata;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_write_data, mem_read_data;
  logic          mem_write, mem_read;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.ADDRESS_LINE(AW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  // Memory: power-up image is addr*5; written locations are overlaid.
  bit         wr_valid [256] = '{default: 1'b0};
  logic [7:0] wr_val   [256];
  assign mem_read_data = wr_valid[mem_address] ? wr_val[mem_address] : 8'(mem_address * 8'd5);
  always @(posedge clock) begin
    if (mem_write) begin
      wr_valid[mem_address] <= 1'b1;
      wr_val[mem_address]   <= mem_write_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [7:0] ref_mem [256];
  bit         m_burst;
  int         m_len, m_wins;
  bit         e_rv_c, e_rv_d;
  logic [7:0] e_rd_c, e_rd_d;
  bit         o_cpu_gnt, o_dma_gnt, o_cpu_stall;
  int         txn = 0;

  task automatic model_reset();
    m_burst = 0; m_len = 0; m_wins = 0;
    e_rv_c = 0; e_rv_d = 0; e_rd_c = 8'h00; e_rd_d = 8'h00;
  endtask

  task automatic drive(input bit cr, input bit cw, input int ca, input int cd,
                       input bit dr, input bit dw, input int da, input int dd, input bit dl);
    cpu_req = cr; cpu_we = cw; cpu_addr = AW'(ca); cpu_wdata = 8'(cd);
    dma_req = dr; dma_we = dw; dma_addr = AW'(da); dma_wdata = 8'(dd); dma_lock = dl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle: check outputs at the negedge, update model, return at posedge+1.
  task automatic step();
    bit eg_c, eg_d, exp_w, exp_r;
    @(negedge clock);
    if (m_burst) begin
      eg_d = dma_req; eg_c = 0;
    end else if (cpu_req && dma_req) begin
      eg_d = (m_wins >= SL); eg_c = !eg_d;
    end else begin
      eg_c = cpu_req; eg_d = dma_req;
    end
    exp_w = (eg_c && cpu_we) || (eg_d && dma_we);
    exp_r = (eg_c && !cpu_we) || (eg_d && !dma_we);
    check("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
    check("dma_gnt", 32'(dma_gnt), 32'(eg_d));
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eg_c));
    check("mem_write", 32'(mem_write), 32'(exp_w));
    check("mem_read", 32'(mem_read), 32'(exp_r));
    if (eg_c) check("mem_addr_cpu", 32'(mem_address), 32'(cpu_addr));
    if (eg_d) check("mem_addr_dma", 32'(mem_address), 32'(dma_addr));
    if (exp_w) check("mem_wdata", 32'(mem_write_data), eg_c ? 32'(cpu_wdata) : 32'(dma_wdata));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_rv_c));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_rd_c));
    check("dma_rvalid", 32'(dma_rvalid), 32'(e_rv_d));
    check("dma_rdata", 32'(dma_rdata), 32'(e_rd_d));
    $display("txn %0d cr=%0b dr=%0b dl=%0b -> cpu_gnt=%0b dma_gnt=%0b addr=%0h rv=%0b/%0b",
             txn, cpu_req, dma_req, dma_lock, cpu_gnt, dma_gnt, mem_address, cpu_rvalid, dma_rvalid);
    txn++;
    o_cpu_gnt = cpu_gnt; o_dma_gnt = dma_gnt; o_cpu_stall = cpu_stall;

    e_rv_c = eg_c && !cpu_we;
    e_rv_d = eg_d && !dma_we;
    if (eg_c) begin
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else        e_rd_c = ref_mem[cpu_addr];
    end
    if (eg_d) begin
      if (dma_we) ref_mem[dma_addr] = dma_wdata;
      else        e_rd_d = ref_mem[dma_addr];
    end
    if (eg_d) begin
      m_len   = m_burst ? m_len + 1 : 1;
      m_burst = dma_lock && (m_len < LM);
    end else begin
      m_burst = 0; m_len = 0;
    end
    if (eg_d || !dma_req) m_wins = 0;
    else if (eg_c)        m_wins = (m_wins + 1 > SL) ? SL : m_wins + 1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit [5:0] dpat, spat;
    int       dcount;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 5);
    model_reset();
    idle();
    cpu_req = 1'b1;
    reset   = 1'b1;
    #2;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_dma_rdata", 32'(dma_rdata), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // CPU-only read of addr 2
    drive(1, 0, 2, 0, 0, 0, 0, 0, 0);
    step();
    check("s1_gnt", 32'(o_cpu_gnt), 32'd1);
    idle();
    check("s1_rvalid", 32'(cpu_rvalid), 32'd1);
    check("s1_rdata", 32'(cpu_rdata), 32'd10);
    step();

    // Both requesting reads for six cycles
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 3, 0, 1, 0, 4, 0, 0);
      step();
      dpat[i] = o_dma_gnt;
      spat[i] = o_cpu_stall;
    end
    check("s2_dma_pattern", 32'(dpat), 32'b010000);
    check("s2_stall_pattern", 32'(spat), 32'b010000);
    idle(); step();

    // DMA write then CPU read back
    drive(0, 0, 0, 0, 1, 1, 8'h20, 8'hA5, 0);
    step();
    drive(1, 0, 8'h20, 0, 0, 0, 0, 0, 0);
    step();
    check("s3_rdata", 32'(cpu_rdata), 32'hA5);
    idle(); step();

    // Full-length lock burst with CPU waiting
    dcount = 0;
    for (int i = 0; i < 9; i++) begin
      drive(i > 0, 0, 8'h10, 0, 1, 0, 8'h30 + i, 0, 1);
      step();
      dcount += int'(o_dma_gnt);
    end
    check("s4_dma_grants", 32'(dcount), 32'd8);
    check("s4_cpu_after", 32'(o_cpu_gnt), 32'd1);
    idle(); step();

    // Lock released on the third cycle
    for (int i = 0; i < 4; i++) begin
      drive(i > 0, 0, 8'h11, 0, 1, 1, 8'h40 + i, 8'h60 + i, i < 2);
      step();
      if (i < 3) check("s5_dma_gnt", 32'(o_dma_gnt), 32'd1);
    end
    check("s5_cpu_4th", 32'(o_cpu_gnt), 32'd1);
    idle(); step();

    // Reset in the middle of a lock with a read return pending
    drive(0, 0, 0, 0, 1, 0, 8'h05, 0, 1);
    step();
    drive(1, 0, 8'h06, 0, 1, 0, 8'h07, 0, 1);
    check("s6_pre_rvalid", 32'(dma_rvalid), 32'd1);
    check("s6_pre_lock", 32'(dma_gnt), 32'd1);
    reset = 1'b1;
    #1;
    check("s6_dma_gnt", 32'(dma_gnt), 32'd0);
    check("s6_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("s6_mem_write", 32'(mem_write), 32'd0);
    check("s6_mem_read", 32'(mem_read), 32'd0);
    check("s6_rvalid", 32'(dma_rvalid), 32'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    step();
    check("s6_arb_cpu", 32'(o_cpu_gnt), 32'd1);
    idle(); step();

    // Random traffic honouring hold-until-grant, with occasional drops
    for (int n = 0; n < 2000; n++) begin
      if (cpu_req && !o_cpu_gnt) begin
        if ($urandom_range(9) == 0) cpu_req = 1'b0;
      end else begin
        cpu_req   = ($urandom_range(3) != 0);
        cpu_we    = $urandom_range(1) == 1;
        cpu_addr  = AW'($urandom_range(15));
        cpu_wdata = 8'($urandom);
      end
      if (dma_req && !o_dma_gnt) begin
        if ($urandom_range(9) == 0) dma_req = 1'b0;
      end else begin
        dma_req   = ($urandom_range(2) != 0);
        dma_we    = $urandom_range(1) == 1;
        dma_addr  = AW'($urandom_range(15));
        dma_wdata = 8'($urandom);
      end
      dma_lock = ($urandom_range(2) != 0);
      step();
    end
    idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
